// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch stage
package fetch_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    HALT   = 2'd2
  } state_t;

  localparam logic [1:0] JMP_NONE = 2'b00;
  localparam logic [1:0] JMP_REL  = 2'b01;
  localparam logic [1:0] JMP_REG  = 2'b10;

  localparam logic [15:0] RESET_PC_DEF   = 16'h0000;
  localparam logic [15:0] EXC_VECTOR_DEF = 16'h0002;
  localparam logic [15:0] NOP_INSTR_DEF  = 16'h0800;

  // Sequential successor; wraps modulo 2^16 by construction.
  function automatic logic [15:0] pc_inc(input logic [15:0] pc);
    return pc + 16'd2;
  endfunction

endpackage

// File: rtl/next_pc_sel.sv
// rtl/next_pc_sel.sv - priority mux choosing the PC that follows the instruction in IR
module next_pc_sel
  import fetch_pkg::*;
#(
  parameter logic [15:0] EXC_VECTOR = EXC_VECTOR_DEF
) (
  input  logic [15:0] pc,
  input  logic [15:0] epc,
  input  logic        hlt,
  input  logic        siic,
  input  logic        rti,
  input  logic [1:0]  jump,
  input  logic [15:0] jump_target,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic [15:0] next_pc,
  output logic        epc_we,
  output logic        align_fault
);

  always_comb begin
    next_pc = pc_inc(pc);
    epc_we  = 1'b0;
    if (hlt) begin
      next_pc = pc;
    end else if (siic) begin
      next_pc = EXC_VECTOR;
      epc_we  = 1'b1;
    end else if (rti) begin
      next_pc = epc;
    end else if (jump == JMP_REL || jump == JMP_REG) begin
      next_pc = jump_target;
    end else if (branch_taken) begin
      next_pc = branch_target;
    end
  end

  // A halting instruction never redirects, so it cannot raise an alignment fault.
  assign align_fault = !hlt && next_pc[0];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC/EPC/IR ownership and imem handshake
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC   = RESET_PC_DEF,
  parameter logic [15:0] EXC_VECTOR = EXC_VECTOR_DEF,
  parameter logic [15:0] NOP_INSTR  = NOP_INSTR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [1:0]  jump,
  input  logic [15:0] jump_target,
  input  logic        siic,
  input  logic        rti,
  input  logic        hlt,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  output logic [15:0] instruction,
  output logic        instr_valid,
  output logic [15:0] pc_plus2,
  output logic [15:0] epc,
  output logic        halted,
  output logic        align_err
);

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] epc_q, epc_d;
  logic        align_q, align_d;

  logic [15:0] next_pc;
  logic        epc_we;
  logic        align_fault;

  next_pc_sel #(
    .EXC_VECTOR(EXC_VECTOR)
  ) u_next_pc_sel (
    .pc           (pc_q),
    .epc          (epc_q),
    .hlt          (hlt),
    .siic         (siic),
    .rti          (rti),
    .jump         (jump),
    .jump_target  (jump_target),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .next_pc      (next_pc),
    .epc_we       (epc_we),
    .align_fault  (align_fault)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= NOP_INSTR;
      epc_q   <= 16'h0000;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      epc_q   <= epc_d;
      align_q <= align_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    epc_d       = epc_q;
    align_d     = align_q;
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state_q)
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = DECODE;
        end
      end
      DECODE: begin
        instr_valid = 1'b1;
        // Redirects are only honoured on the cycle the instruction leaves DECODE.
        if (!stall) begin
          ir_d = NOP_INSTR;
          if (hlt) begin
            state_d = HALT;
          end else if (align_fault) begin
            align_d = 1'b1;
            state_d = HALT;
          end else begin
            pc_d    = next_pc;
            state_d = FETCH;
            if (epc_we) begin
              epc_d = pc_inc(pc_q);
            end
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign imem_addr   = pc_q;
  assign instruction = ir_q;
  assign pc_plus2    = pc_inc(pc_q);
  assign epc         = epc_q;
  assign align_err   = align_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic [1:0]  jump;
  logic [15:0] jump_target;
  logic        siic;
  logic        rti;
  logic        hlt;
  logic [15:0] imem_rdata;
  logic        imem_ready;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] instruction;
  logic        instr_valid;
  logic [15:0] pc_plus2;
  logic [15:0] epc;
  logic        halted;
  logic        align_err;

  int checks = 0;
  int failures = 0;

  logic [15:0] exp_fetch[$];
  logic [15:0] exp_instr[$];

  fetch_unit dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .siic         (siic),
    .rti          (rti),
    .hlt          (hlt),
    .imem_rdata   (imem_rdata),
    .imem_ready   (imem_ready),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .instruction  (instruction),
    .instr_valid  (instr_valid),
    .pc_plus2     (pc_plus2),
    .epc          (epc),
    .halted       (halted),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every accepted fetch and every instruction leaving DECODE is matched against the scoreboard.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (imem_req && imem_ready) begin
        if (exp_fetch.size() == 0) check("unexpected_fetch", {16'h0, imem_addr}, 32'hFFFF_FFFF);
        else check("fetch_addr", {16'h0, imem_addr}, {16'h0, exp_fetch.pop_front()});
      end
      if (instr_valid && !stall) begin
        if (exp_instr.size() == 0) check("unexpected_instr", {16'h0, instruction}, 32'hFFFF_FFFF);
        else check("ir_value", {16'h0, instruction}, {16'h0, exp_instr.pop_front()});
      end
    end
  end

  task automatic clear_redirects();
    branch_taken = 1'b0; branch_target = 16'h0; jump = 2'b00; jump_target = 16'h0;
    siic = 1'b0; rti = 1'b0; hlt = 1'b0;
  endtask

  // Entered at posedge+1 with the DUT in FETCH; leaves at posedge+1 after the instruction retires.
  task automatic do_instr(input logic [15:0] pc, input logic [15:0] ins, input int miss, input int stl,
                          input logic hl, input logic sc, input logic rt,
                          input logic [1:0] jmp, input logic [15:0] jt,
                          input logic br, input logic [15:0] bt);
    exp_fetch.push_back(pc);
    exp_instr.push_back(ins);
    imem_ready = 1'b0;
    imem_rdata = 16'hDEAD;
    for (int i = 0; i < miss; i++) begin
      @(negedge clk);
      check("miss_req", {31'h0, imem_req}, 32'h1);
      check("miss_ir", {16'h0, instruction}, 32'h0800);
      @(posedge clk); #1;
    end
    imem_ready = 1'b1;
    imem_rdata = ins;
    @(posedge clk); #1;
    imem_ready = 1'b0;
    imem_rdata = 16'hDEAD;
    stall = 1'b1;
    branch_taken = 1'b1; branch_target = 16'h0100; jump = 2'b10; jump_target = 16'h0200;
    siic = 1'b1; rti = 1'b1; hlt = 1'b1;
    for (int i = 0; i < stl; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, instr_valid}, 32'h1);
      check("stall_req", {31'h0, imem_req}, 32'h0);
      check("stall_halted", {31'h0, halted}, 32'h0);
      check("stall_pc", {16'h0, imem_addr}, {16'h0, pc});
      @(posedge clk); #1;
    end
    stall = 1'b0;
    branch_taken = br; branch_target = bt; jump = jmp; jump_target = jt;
    siic = sc; rti = rt; hlt = hl;
    @(negedge clk);
    check("decode_valid", {31'h0, instr_valid}, 32'h1);
    check("pc_plus2", {16'h0, pc_plus2}, {16'h0, pc + 16'd2});
    @(posedge clk); #1;
    clear_redirects();
  endtask

  task automatic hold_reset();
    rst = 1'b0;
    imem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    stall = 1'b0;
    imem_ready = 1'b0;
    imem_rdata = 16'h0;
    clear_redirects();
    @(negedge clk);
    check("rst_addr", {16'h0, imem_addr}, 32'h0);
    check("rst_ir", {16'h0, instruction}, 32'h0800);
    check("rst_valid", {31'h0, instr_valid}, 32'h0);
    check("rst_halted", {31'h0, halted}, 32'h0);
    check("rst_align", {31'h0, align_err}, 32'h0);
    check("rst_epc", {16'h0, epc}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("rst_req", {31'h0, imem_req}, 32'h1);
    @(posedge clk); #1;

    // sequential NOP stream, one miss run, one stall with ignored redirects
    do_instr(16'h0000, 16'h0800, 0, 0, 0, 0, 0, 2'b00, 16'h0, 0, 16'h0);
    do_instr(16'h0002, 16'h0800, 0, 0, 0, 0, 0, 2'b00, 16'h0, 0, 16'h0);
    do_instr(16'h0004, 16'h1111, 3, 0, 0, 0, 0, 2'b00, 16'h0, 0, 16'h0);
    do_instr(16'h0006, 16'h2222, 0, 2, 0, 0, 0, 2'b00, 16'h0, 0, 16'h0);
    check("no_epc_on_stall", {16'h0, epc}, 32'h0);
    // jump beats branch, then branch alone
    do_instr(16'h0008, 16'h3333, 0, 0, 0, 0, 0, 2'b10, 16'h0040, 1, 16'h0080);
    do_instr(16'h0040, 16'h4444, 0, 0, 0, 0, 0, 2'b00, 16'h0, 1, 16'h0010);
    // SIIC together with RTI: SIIC wins
    do_instr(16'h0010, 16'h5555, 0, 0, 0, 1, 1, 2'b00, 16'h0, 0, 16'h0);
    check("siic_epc", {16'h0, epc}, 32'h0012);
    do_instr(16'h0002, 16'h6666, 0, 0, 0, 0, 0, 2'b01, 16'h0030, 0, 16'h0);
    do_instr(16'h0030, 16'h7777, 0, 0, 0, 0, 0, 2'b11, 16'h0050, 0, 16'h0);
    do_instr(16'h0032, 16'h8888, 0, 0, 0, 0, 1, 2'b00, 16'h0, 0, 16'h0);
    // wrap at top of address space
    do_instr(16'h0012, 16'h9999, 0, 0, 0, 0, 0, 2'b10, 16'hFFFE, 0, 16'h0);
    do_instr(16'hFFFE, 16'hAAAA, 0, 0, 0, 0, 0, 2'b00, 16'h0, 0, 16'h0);
    // HALT after stall
    do_instr(16'h0000, 16'hBBBB, 0, 2, 1, 0, 0, 2'b00, 16'h0, 0, 16'h0);
    check("halt_pc", {16'h0, imem_addr}, 32'h0);
    check("halt_align", {31'h0, align_err}, 32'h0);
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("halt_flag", {31'h0, halted}, 32'h1);
      check("halt_req", {31'h0, imem_req}, 32'h0);
      check("halt_valid", {31'h0, instr_valid}, 32'h0);
      @(posedge clk); #1;
    end

    // reset mid-fetch at PC=0020 with a pending response
    hold_reset();
    check("rst2_epc", {16'h0, epc}, 32'h0);
    check("rst2_halted", {31'h0, halted}, 32'h0);
    @(posedge clk); #1;
    do_instr(16'h0000, 16'hCCCC, 0, 0, 0, 0, 0, 2'b10, 16'h0020, 0, 16'h0);
    check("pre_rst_pc", {16'h0, imem_addr}, 32'h0020);
    imem_ready = 1'b1;
    imem_rdata = 16'hBEEF;
    #1;
    rst = 1'b0;
    #1;
    check("async_pc", {16'h0, imem_addr}, 32'h0);
    check("async_ir", {16'h0, instruction}, 32'h0800);
    check("async_valid", {31'h0, instr_valid}, 32'h0);
    imem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // odd redirect target
    do_instr(16'h0000, 16'hDDDD, 0, 0, 0, 0, 0, 2'b10, 16'h0041, 0, 16'h0);
    @(negedge clk);
    check("align_err", {31'h0, align_err}, 32'h1);
    check("align_halted", {31'h0, halted}, 32'h1);
    check("align_pc", {16'h0, imem_addr}, 32'h0);
    check("align_req", {31'h0, imem_req}, 32'h0);
    @(posedge clk); #1;

    check("fetch_queue_empty", exp_fetch.size(), 32'h0);
    check("instr_queue_empty", exp_instr.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
